// File: rtl/coef_bank_pkg.sv
// Shared constants and FSM encoding for the double-buffered coefficient bank.
package coef_bank_pkg;
  localparam int NCOEF_DEF  = 12;
  localparam int COEF_W_DEF = 10;
  localparam int IDX_W      = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_FULL = 2'd2
  } state_e;
endpackage

// File: rtl/coef_bank_if.sv
// Controller/filter-facing bundle of the coefficient bank.
interface coef_bank_if #(parameter int COEF_W = coef_bank_pkg::COEF_W_DEF);
  import coef_bank_pkg::*;

  logic              load_start;
  logic [COEF_W-1:0] coef_in;
  logic              coef_valid;
  logic              coef_ready;
  logic              frame_strobe;
  logic [IDX_W-1:0]  rd_idx;
  logic [COEF_W-1:0] rd_coef;
  logic              set_full;
  logic              swapped;

  modport master (
    output load_start, coef_in, coef_valid, frame_strobe, rd_idx,
    input  coef_ready, rd_coef, set_full, swapped
  );

  modport slave (
    input  load_start, coef_in, coef_valid, frame_strobe, rd_idx,
    output coef_ready, rd_coef, set_full, swapped
  );
endinterface

// File: rtl/coef_regfile.sv
// Shadow/active register pair: indexed shadow writes, single-edge bulk copy,
// combinational active read (out-of-range index reads zero).
module coef_regfile
  import coef_bank_pkg::*;
#(
  parameter int NCOEF  = NCOEF_DEF,
  parameter int COEF_W = COEF_W_DEF
) (
  input  logic              clk,
  input  logic              rst_an,
  input  logic              we_i,
  input  logic [IDX_W-1:0]  waddr_i,
  input  logic [COEF_W-1:0] wdata_i,
  input  logic              copy_i,
  input  logic [IDX_W-1:0]  raddr_i,
  output logic [COEF_W-1:0] rdata_o
);
  logic [NCOEF-1:0][COEF_W-1:0] shadow_q;
  logic [NCOEF-1:0][COEF_W-1:0] active_q;

  always_ff @(posedge clk or negedge rst_an) begin
    if (!rst_an) begin
      shadow_q <= '0;
      active_q <= '0;
    end else begin
      for (int i = 0; i < NCOEF; i++) begin
        if (we_i && waddr_i == IDX_W'(i)) shadow_q[i] <= wdata_i;
      end
      if (copy_i) active_q <= shadow_q;
    end
  end

  always_comb begin
    rdata_o = '0;
    for (int i = 0; i < NCOEF; i++) begin
      if (raddr_i == IDX_W'(i)) rdata_o = active_q[i];
    end
  end
endmodule

// File: rtl/coef_bank.sv
// Coefficient bank: loads a shadow set over a valid/ready handshake and
// publishes it to the active set on the next frame strobe after it is full.
module coef_bank
  import coef_bank_pkg::*;
#(
  parameter int NCOEF  = NCOEF_DEF,
  parameter int COEF_W = COEF_W_DEF
) (
  input  logic        clk,
  input  logic        rst_an,
  coef_bank_if.slave  bus
);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NCOEF - 1);
  localparam logic [COEF_W-1:0] NEG_ZERO = {1'b1, {(COEF_W-1){1'b0}}};

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  wr_idx_q, wr_idx_d;
  logic              swapped_q;
  logic              coef_ready, set_full, wr_en, copy_en;
  logic [COEF_W-1:0] wr_data;

  always_ff @(posedge clk or negedge rst_an) begin
    if (!rst_an) begin
      state_q   <= ST_IDLE;
      wr_idx_q  <= '0;
      swapped_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_idx_q  <= wr_idx_d;
      swapped_q <= copy_en;
    end
  end

  // load_start pre-empts everything, including a same-cycle transfer.
  always_comb begin
    state_d  = state_q;
    wr_idx_d = wr_idx_q;
    if (bus.load_start) begin
      state_d  = ST_LOAD;
      wr_idx_d = '0;
    end else begin
      unique case (state_q)
        ST_LOAD: if (bus.coef_valid) begin
          wr_idx_d = wr_idx_q + 1'b1;
          if (wr_idx_q == LAST_IDX) begin
            state_d  = ST_FULL;
            wr_idx_d = '0;
          end
        end
        ST_FULL: if (bus.frame_strobe) state_d = ST_IDLE;
        default: ;
      endcase
    end
  end

  // Copy is independent of load_start so a coincident restart still swaps.
  always_comb begin
    coef_ready = 1'b0;
    set_full   = 1'b0;
    unique case (state_q)
      ST_LOAD: coef_ready = 1'b1;
      ST_FULL: set_full   = 1'b1;
      default: ;
    endcase
    wr_en   = coef_ready && bus.coef_valid && !bus.load_start;
    copy_en = set_full && bus.frame_strobe;
  end

  assign wr_data = (bus.coef_in == NEG_ZERO) ? '0 : bus.coef_in;

  coef_regfile #(.NCOEF(NCOEF), .COEF_W(COEF_W)) u_regfile (
    .clk     (clk),
    .rst_an  (rst_an),
    .we_i    (wr_en),
    .waddr_i (wr_idx_q),
    .wdata_i (wr_data),
    .copy_i  (copy_en),
    .raddr_i (bus.rd_idx),
    .rdata_o (bus.rd_coef)
  );

  assign bus.coef_ready = coef_ready;
  assign bus.set_full   = set_full;
  assign bus.swapped    = swapped_q;
endmodule

// File: tb/tb_coef_bank.sv
// Bench for coef_bank: queue-based reference model of the load/swap rules.
module tb_coef_bank;
  import coef_bank_pkg::*;
  localparam int N = 12;
  localparam int W = 10;

  logic clk = 1'b0;
  logic rst_an = 1'b0;
  always #5 clk = ~clk;

  coef_bank_if #(.COEF_W(W)) bus();
  coef_bank #(.NCOEF(N), .COEF_W(W)) dut (.clk(clk), .rst_an(rst_an), .bus(bus));

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: accepted words queue, active image, status flags.
  logic [W-1:0] act [N];
  logic [W-1:0] pend [$];
  bit loading, set_rdy, exp_sw;

  function automatic logic [W-1:0] canon(logic [W-1:0] v);
    return (v[W-1] && v[W-2:0] == '0) ? '0 : v;
  endfunction

  function automatic logic [W-1:0] exp_rd(int idx);
    return (idx < N) ? act[idx] : '0;
  endfunction

  task automatic model_clear();
    loading = 0; set_rdy = 0; exp_sw = 0;
    pend.delete();
    for (int i = 0; i < N; i++) act[i] = '0;
  endtask

  // One clock: model consumes the inputs the DUT samples, then pulses drop.
  task automatic tick();
    bit sw;
    @(posedge clk);
    sw = set_rdy && bus.frame_strobe;
    if (sw) begin
      for (int i = 0; i < N; i++) act[i] = pend[i];
      set_rdy = 0;
    end
    if (bus.load_start) begin
      loading = 1; set_rdy = 0; pend.delete();
    end else if (loading && bus.coef_valid) begin
      pend.push_back(canon(bus.coef_in));
      if (pend.size() == N) begin loading = 0; set_rdy = 1; end
    end
    exp_sw = sw;
    @(negedge clk);
    bus.load_start = 0; bus.frame_strobe = 0; bus.coef_valid = 0;
  endtask

  task automatic test_reset();
    bus.load_start = 0; bus.coef_valid = 0; bus.frame_strobe = 0;
    bus.coef_in = '0; bus.rd_idx = '0;
    model_clear();
    #2;
    n_tests++; if (bus.coef_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b want 0", bus.coef_ready); end
    n_tests++; if (bus.set_full !== 1'b0) begin n_fail++; $display("FAIL reset_full: got %b want 0", bus.set_full); end
    n_tests++; if (bus.swapped !== 1'b0) begin n_fail++; $display("FAIL reset_swapped: got %b want 0", bus.swapped); end
    @(negedge clk); rst_an = 1;
    tick();
    for (int i = 0; i < 16; i++) begin
      bus.rd_idx = 4'(i); #1;
      n_tests++; if (bus.rd_coef !== '0) begin n_fail++; $display("FAIL reset_rd idx=%0d: got %h want 000", i, bus.rd_coef); end
    end
    n_tests++; if (bus.coef_ready !== 1'b0 || bus.set_full !== 1'b0) begin n_fail++; $display("FAIL post_reset_status: got rdy=%b full=%b want 0/0", bus.coef_ready, bus.set_full); end
  endtask

  task automatic test_basic_load();
    bus.load_start = 1; tick();
    n_tests++; if (bus.coef_ready !== 1'b1) begin n_fail++; $display("FAIL basic_ready: got %b want 1", bus.coef_ready); end
    for (int k = 1; k <= N; k++) begin
      bus.coef_in = W'(8 * k); bus.coef_valid = 1; tick();
      n_tests++; if (bus.set_full !== (k == N)) begin n_fail++; $display("FAIL basic_full k=%0d: got %b want %b", k, bus.set_full, k == N); end
    end
    n_tests++; if (bus.coef_ready !== 1'b0) begin n_fail++; $display("FAIL basic_ready_full: got %b want 0", bus.coef_ready); end
    bus.rd_idx = 4'd3; #1;
    n_tests++; if (bus.rd_coef !== 10'h000) begin n_fail++; $display("FAIL basic_preswap: got %h want 000", bus.rd_coef); end
    bus.frame_strobe = 1; tick();
    n_tests++; if (bus.swapped !== 1'b1) begin n_fail++; $display("FAIL basic_swapped: got %b want 1", bus.swapped); end
    n_tests++; if (bus.rd_coef !== 10'h020) begin n_fail++; $display("FAIL basic_rd3: got %h want 020", bus.rd_coef); end
    n_tests++; if (bus.set_full !== 1'b0) begin n_fail++; $display("FAIL basic_full_clr: got %b want 0", bus.set_full); end
    tick();
    n_tests++; if (bus.swapped !== 1'b0) begin n_fail++; $display("FAIL basic_swap_pulse: got %b want 0", bus.swapped); end
    for (int i = 0; i < N; i++) begin
      bus.rd_idx = 4'(i); #1;
      n_tests++; if (bus.rd_coef !== W'(8 * (i + 1))) begin n_fail++; $display("FAIL basic_rd idx=%0d: got %h want %h", i, bus.rd_coef, W'(8 * (i + 1))); end
    end
  endtask

  task automatic test_valid_toggle();
    int acc = 0;
    int cyc = 0;
    bus.load_start = 1; tick();
    while (acc < N && cyc < 100) begin
      bus.coef_in = W'($urandom); bus.coef_valid = cyc[0];
      if (bus.coef_valid && bus.coef_ready) acc++;
      tick(); cyc++;
      n_tests++; if (bus.set_full !== (acc == N)) begin n_fail++; $display("FAIL toggle_full acc=%0d: got %b want %b", acc, bus.set_full, acc == N); end
    end
    n_tests++; if (acc != N || pend.size() != N) begin n_fail++; $display("FAIL toggle_count: got %0d want %0d", acc, N); end
    bus.frame_strobe = 1; tick();
    for (int i = 0; i < N; i++) begin
      bus.rd_idx = 4'(i); #1;
      n_tests++; if (bus.rd_coef !== exp_rd(i)) begin n_fail++; $display("FAIL toggle_rd idx=%0d: got %h want %h", i, bus.rd_coef, exp_rd(i)); end
    end
  endtask

  task automatic test_restart();
    bus.load_start = 1; tick();
    for (int k = 0; k < 5; k++) begin bus.coef_in = W'($urandom); bus.coef_valid = 1; tick(); end
    bus.load_start = 1; tick();
    for (int k = 0; k < N; k++) begin bus.coef_in = 10'h1FF; bus.coef_valid = 1; tick(); end
    n_tests++; if (bus.set_full !== 1'b1) begin n_fail++; $display("FAIL restart_full: got %b want 1", bus.set_full); end
    bus.frame_strobe = 1; tick();
    for (int i = 0; i < N; i++) begin
      bus.rd_idx = 4'(i); #1;
      n_tests++; if (bus.rd_coef !== 10'h1FF) begin n_fail++; $display("FAIL restart_rd idx=%0d: got %h want 1ff", i, bus.rd_coef); end
    end
  endtask

  task automatic test_strobe_in_load();
    bus.load_start = 1; tick();
    for (int k = 0; k < 7; k++) begin bus.coef_in = W'($urandom); bus.coef_valid = 1; tick(); end
    bus.frame_strobe = 1; tick();
    n_tests++; if (bus.swapped !== 1'b0) begin n_fail++; $display("FAIL loadstrobe_swapped: got %b want 0", bus.swapped); end
    for (int i = 0; i < N; i++) begin
      bus.rd_idx = 4'(i); #1;
      n_tests++; if (bus.rd_coef !== 10'h1FF) begin n_fail++; $display("FAIL loadstrobe_rd idx=%0d: got %h want 1ff", i, bus.rd_coef); end
    end
    // A transfer coinciding with load_start is dropped.
    bus.load_start = 1; bus.coef_valid = 1; bus.coef_in = 10'h155; tick();
    for (int k = 0; k < N; k++) begin bus.coef_in = W'(k + 1); bus.coef_valid = 1; tick(); end
    bus.frame_strobe = 1; tick();
    for (int i = 0; i < N; i++) begin
      bus.rd_idx = 4'(i); #1;
      n_tests++; if (bus.rd_coef !== W'(i + 1)) begin n_fail++; $display("FAIL lsdrop_rd idx=%0d: got %h want %h", i, bus.rd_coef, W'(i + 1)); end
    end
  endtask

  task automatic test_negzero_and_overlap();
    bus.load_start = 1; tick();
    for (int k = 0; k < N; k++) begin
      bus.coef_in = (k == 4) ? 10'h200 : W'($urandom_range(1, 511)); bus.coef_valid = 1; tick();
    end
    // Strobe and restart in the same FULL cycle: swap, then reload.
    bus.frame_strobe = 1; bus.load_start = 1; tick();
    n_tests++; if (bus.swapped !== 1'b1) begin n_fail++; $display("FAIL overlap_swapped: got %b want 1", bus.swapped); end
    n_tests++; if (bus.coef_ready !== 1'b1) begin n_fail++; $display("FAIL overlap_ready: got %b want 1", bus.coef_ready); end
    bus.rd_idx = 4'd4; #1;
    n_tests++; if (bus.rd_coef !== 10'h000) begin n_fail++; $display("FAIL negzero_rd: got %h want 000", bus.rd_coef); end
    bus.rd_idx = 4'd13; #1;
    n_tests++; if (bus.rd_coef !== 10'h000) begin n_fail++; $display("FAIL oob_rd13: got %h want 000", bus.rd_coef); end
    for (int i = 0; i < N; i++) begin
      bus.rd_idx = 4'(i); #1;
      n_tests++; if (bus.rd_coef !== exp_rd(i)) begin n_fail++; $display("FAIL overlap_rd idx=%0d: got %h want %h", i, bus.rd_coef, exp_rd(i)); end
    end
  endtask

  task automatic test_reset_midload();
    bus.load_start = 1; tick();
    for (int k = 0; k < 6; k++) begin bus.coef_in = W'($urandom); bus.coef_valid = 1; tick(); end
    #2 rst_an = 0; #1;
    model_clear();
    n_tests++; if (bus.coef_ready !== 1'b0) begin n_fail++; $display("FAIL midreset_ready: got %b want 0", bus.coef_ready); end
    @(negedge clk); rst_an = 1;
    for (int k = 0; k < 6; k++) begin bus.coef_in = W'($urandom); bus.coef_valid = 1; tick(); end
    bus.frame_strobe = 1; tick();
    n_tests++; if (bus.swapped !== 1'b0) begin n_fail++; $display("FAIL midreset_swapped: got %b want 0", bus.swapped); end
    n_tests++; if (bus.set_full !== 1'b0) begin n_fail++; $display("FAIL midreset_full: got %b want 0", bus.set_full); end
    for (int i = 0; i < 16; i++) begin
      bus.rd_idx = 4'(i); #1;
      n_tests++; if (bus.rd_coef !== '0) begin n_fail++; $display("FAIL midreset_rd idx=%0d: got %h want 000", i, bus.rd_coef); end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      bus.load_start   = ($urandom_range(0, 39) == 0);
      bus.frame_strobe = ($urandom_range(0, 5) == 0);
      bus.coef_valid   = ($urandom_range(0, 3) != 0);
      bus.coef_in      = ($urandom_range(0, 7) == 0) ? 10'h200 : W'($urandom);
      bus.rd_idx       = 4'($urandom_range(0, 15));
      tick();
      n_tests++;
      if (bus.coef_ready !== loading || bus.set_full !== set_rdy || bus.swapped !== exp_sw ||
          bus.rd_coef !== exp_rd(int'(bus.rd_idx))) begin
        n_fail++;
        $display("FAIL random c=%0d: got rdy=%b full=%b sw=%b rd=%h want %b %b %b %h", c,
                 bus.coef_ready, bus.set_full, bus.swapped, bus.rd_coef,
                 loading, set_rdy, exp_sw, exp_rd(int'(bus.rd_idx)));
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_load();
    test_valid_toggle();
    test_restart();
    test_strobe_in_load();
    test_negzero_and_overlap();
    test_reset_midload();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
